// File: rtl/button_cmd_pkg.sv
// Shared types and constants for the button command queue.
//   cmd_t       : 3-bit game command code (5..7 never produced)
//   PRIO_ORDER  : arbitration order, highest priority first
//   rpt_state_t : auto-repeat FSM encoding
//   CNT_W       : width of the auto-repeat counters
package button_cmd_pkg;

   localparam int CNT_W    = 24;
   localparam int NUM_CMDS = 5;

   typedef enum logic [2:0] {
      CMD_ROTATE    = 3'd0,
      CMD_RIGHT     = 3'd1,
      CMD_LEFT      = 3'd2,
      CMD_SOFT_DROP = 3'd3,
      CMD_HARD_DROP = 3'd4
   } cmd_t;

   localparam cmd_t PRIO_ORDER [NUM_CMDS] = '{
      CMD_ROTATE, CMD_HARD_DROP, CMD_SOFT_DROP, CMD_LEFT, CMD_RIGHT
   };

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

endpackage

// File: rtl/auto_repeat_unit.sv
// DAS/ARR auto-repeat for one held button.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous return to IDLE, suppresses tick
//   level      : synchronized held level
//   tick       : one-cycle repeat event (combinational from state/level)
// First tick comes DAS_DELAY cycles after the level is first sampled high,
// then every ARR_PERIOD cycles while it stays high.
module auto_repeat_unit
   import button_cmd_pkg::*;
#(
   parameter logic [CNT_W-1:0] DAS_DELAY  = 24'd6_000_000,
   parameter logic [CNT_W-1:0] ARR_PERIOD = 24'd1_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic level,
   output logic tick
);

   localparam logic [CNT_W-1:0] DAS_LAST = DAS_DELAY - 24'd1;
   localparam logic [CNT_W-1:0] ARR_LAST = ARR_PERIOD - 24'd1;

   rpt_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      if (flush || !level) begin
         state_d = RPT_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RPT_IDLE: begin
               state_d = RPT_DELAY;
               cnt_d   = '0;
            end
            RPT_DELAY: begin
               if (cnt_q == DAS_LAST) begin
                  tick    = 1'b1;
                  state_d = RPT_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
            RPT_REPEAT: begin
               if (cnt_q == ARR_LAST) begin
                  tick  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 24'd1;
               end
            end
            default: begin
               state_d = RPT_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RPT_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/button_cmd_queue.sv
// Turns button press pulses and held levels (with auto-repeat on E/W/S)
// into a queued command stream for the game state machine.
//   I_PLS_BUTTON_*   : single-cycle press pulses
//   I_LVL_BUTTON_E/W/S : held levels feeding the auto-repeat units
//   I_FLUSH          : clears FIFO, pending flags, drop flag, repeat FSMs
//   O_CMD_VALID/O_CMD/I_CMD_READY : valid/ready output of the FIFO head
//   O_DROP           : one-cycle pulse when an event merged into a set flag
// Events set per-command pending flags; a fixed-priority arbiter moves one
// flag per cycle into the FIFO.
module button_cmd_queue
   import button_cmd_pkg::*;
#(
   parameter logic [CNT_W-1:0] DAS_DELAY  = 24'd6_000_000,
   parameter logic [CNT_W-1:0] ARR_PERIOD = 24'd1_500_000,
   parameter int               FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       I_PLS_BUTTON_C,
   input  logic       I_PLS_BUTTON_E,
   input  logic       I_PLS_BUTTON_W,
   input  logic       I_PLS_BUTTON_S,
   input  logic       I_PLS_BUTTON_N,
   input  logic       I_LVL_BUTTON_E,
   input  logic       I_LVL_BUTTON_W,
   input  logic       I_LVL_BUTTON_S,
   input  logic       I_FLUSH,
   output logic       O_CMD_VALID,
   output logic [2:0] O_CMD,
   input  logic       I_CMD_READY,
   output logic       O_DROP
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int FCW   = PTR_W + 1;

   // Repeat units ordered E, W, S
   logic [2:0] rpt_lvl, rpt_tick;
   assign rpt_lvl = {I_LVL_BUTTON_S, I_LVL_BUTTON_W, I_LVL_BUTTON_E};

   for (genvar g = 0; g < 3; g++) begin : g_rpt
      auto_repeat_unit #(
         .DAS_DELAY (DAS_DELAY),
         .ARR_PERIOD(ARR_PERIOD)
      ) u_rpt (
         .clk  (clk),
         .rst_n(rst_n),
         .flush(I_FLUSH),
         .level(rpt_lvl[g]),
         .tick (rpt_tick[g])
      );
   end

   logic [NUM_CMDS-1:0] evt, clr, pend_q, pend_d;
   cmd_t                mem_q [FIFO_DEPTH];
   cmd_t                mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCW-1:0]      cnt_q, cnt_d;
   cmd_t                last_q, last_d, head, push_cmd;
   logic                drop_q, drop_d, full, push, pop;

   // Pulse and tick on one command OR together: a single event, never a drop
   always_comb begin
      evt                = '0;
      evt[CMD_ROTATE]    = I_PLS_BUTTON_C;
      evt[CMD_RIGHT]     = I_PLS_BUTTON_E | rpt_tick[0];
      evt[CMD_LEFT]      = I_PLS_BUTTON_W | rpt_tick[1];
      evt[CMD_SOFT_DROP] = I_PLS_BUTTON_S | rpt_tick[2];
      evt[CMD_HARD_DROP] = I_PLS_BUTTON_N;
   end

   assign full        = (cnt_q == FCW'(FIFO_DEPTH));
   assign O_CMD_VALID = (cnt_q != '0);
   // Empty FIFO shows the last head value rather than stale storage
   assign head        = O_CMD_VALID ? mem_q[rd_ptr_q] : last_q;
   assign O_CMD       = head;
   assign pop         = O_CMD_VALID & I_CMD_READY;
   assign O_DROP      = drop_q;

   // Fixed-priority pick: scan lowest to highest so the highest set wins.
   // Full blocks the push even when a pop frees a slot this cycle.
   always_comb begin
      push_cmd = CMD_ROTATE;
      clr      = '0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (pend_q[PRIO_ORDER[i]]) push_cmd = PRIO_ORDER[i];
      end
      push = (|pend_q) & ~full;
      if (push) clr[push_cmd] = 1'b1;
   end

   always_comb begin
      // An event on the flag being cleared re-arms it without a drop
      pend_d   = (pend_q & ~clr) | evt;
      drop_d   = |(evt & pend_q & ~clr);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = head;
      if (push) begin
         mem_d[wr_ptr_q] = push_cmd;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + FCW'(push) - FCW'(pop);
      if (I_FLUSH) begin
         pend_d   = '0;
         drop_d   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= '0;
         mem_q    <= '{default: CMD_ROTATE};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= CMD_ROTATE;
         drop_q   <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_button_cmd_queue.sv
module tb_button_cmd_queue;
   localparam int DAS = 8, ARR = 4, DEPTH = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic pc = 0, pe = 0, pw = 0, ps = 0, pn = 0;
   logic le = 0, lw = 0, ls = 0, flush = 0, ready = 1;
   logic valid, drop;
   logic [2:0] cmd;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   button_cmd_queue #(
      .DAS_DELAY(24'd8), .ARR_PERIOD(24'd4), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .I_PLS_BUTTON_C(pc), .I_PLS_BUTTON_E(pe), .I_PLS_BUTTON_W(pw),
      .I_PLS_BUTTON_S(ps), .I_PLS_BUTTON_N(pn),
      .I_LVL_BUTTON_E(le), .I_LVL_BUTTON_W(lw), .I_LVL_BUTTON_S(ls),
      .I_FLUSH(flush), .O_CMD_VALID(valid), .O_CMD(cmd),
      .I_CMD_READY(ready), .O_DROP(drop)
   );

   // Reference model: pending set, queue, hold-length based repeat timing
   bit pend [5];
   int q [$];
   bit drop_m;
   int last_m;
   int h [3];
   bit act [3];
   int prio [5] = '{0, 4, 3, 2, 1};

   function automatic int vis_cmd();
      return (q.size() != 0) ? q[0] : last_m;
   endfunction

   task automatic model_reset();
      pend = '{default: 0};
      q.delete();
      drop_m = 0;
      last_m = 0;
      h = '{default: 0};
      act = '{default: 0};
   endtask

   task automatic model_step();
      bit lv [3];
      bit tk [3];
      bit ev [5];
      int pushed;
      bit pop;
      lv = '{le, lw, ls};
      for (int r = 0; r < 3; r++) begin
         tk[r] = 0;
         if (lv[r]) begin
            int hh;
            hh = act[r] ? h[r] + 1 : 0;
            tk[r] = !flush && hh >= DAS && ((hh - DAS) % ARR) == 0;
            h[r] = hh;
            act[r] = !flush;
         end else begin
            act[r] = 0;
         end
      end
      last_m = vis_cmd();
      if (flush) begin
         pend = '{default: 0};
         q.delete();
         drop_m = 0;
      end else begin
         ev[0] = pc; ev[1] = pe | tk[0]; ev[2] = pw | tk[1];
         ev[3] = ps | tk[2]; ev[4] = pn;
         pop = (q.size() != 0) && ready;
         pushed = -1;
         if (q.size() < DEPTH)
            for (int i = 4; i >= 0; i--) if (pend[prio[i]]) pushed = prio[i];
         drop_m = 0;
         for (int c = 0; c < 5; c++) begin
            if (ev[c] && pend[c] && c != pushed) drop_m = 1;
            if (c == pushed) pend[c] = 0;
            if (ev[c]) pend[c] = 1;
         end
         if (pop) void'(q.pop_front());
         if (pushed >= 0) q.push_back(pushed);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_pulses();
      pc = 0; pe = 0; pw = 0; ps = 0; pn = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || cmd !== 3'd0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b cmd=%0d drop=%b want 0/0/0", valid, cmd, drop);
      end
      rst_n = 1;
      model_reset();
      cycle();
      checks++;
      if (valid !== 1'b0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: valid=%b drop=%b want 0/0", valid, drop);
      end
   endtask

   task automatic test_single();
      ready = 1;
      pc = 1;
      cycle();
      clr_pulses();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL single_k1: valid=%b want 0", valid);
      end
      cycle();
      checks++;
      if (valid !== 1'b1 || cmd !== 3'd0) begin
         errors++; $display("FAIL single_k2: valid=%b cmd=%0d want 1/0", valid, cmd);
      end
      cycle();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL single_one_beat: valid=%b want 0", valid);
      end
   endtask

   task automatic test_burst();
      int exp [3] = '{0, 4, 2};
      ready = 1;
      pc = 1; pn = 1; pw = 1;
      cycle();
      clr_pulses();
      cycle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (valid !== 1'b1 || cmd !== 3'(exp[i]) || drop !== 1'b0) begin
            errors++;
            $display("FAIL burst_%0d: valid=%b cmd=%0d drop=%b want 1/%0d/0", i, valid, cmd, drop, exp[i]);
         end
         cycle();
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL burst_end: valid=%b want 0", valid);
      end
   endtask

   task automatic test_repeat();
      int beats = 0;
      bit got, want;
      ready = 1;
      for (int n = 0; n < 45; n++) begin
         lw = (n < 20);
         pw = (n == 0);
         cycle();
         got  = valid && cmd == 3'd2;
         want = (n + 1 == 2) || (n + 1 == 10) || (n + 1 == 14) || (n + 1 == 18);
         if (got) beats++;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL repeat_cyc%0d: left_beat=%b want %b", n + 1, got, want);
         end
      end
      pw = 0;
      checks++;
      if (beats != 4) begin
         errors++; $display("FAIL repeat_count: beats=%0d want 4", beats);
      end
   endtask

   task automatic fill_fifo();
      ready = 0;
      pc = 1; pe = 1; pw = 1; ps = 1; pn = 1;
      cycle();
      clr_pulses();
      repeat (4) cycle();
   endtask

   task automatic test_full_drop();
      int exp [5] = '{0, 4, 3, 2, 1};
      fill_fifo();
      checks++;
      if (valid !== 1'b1 || cmd !== 3'd0 || drop !== 1'b0) begin
         errors++; $display("FAIL full_head: valid=%b cmd=%0d drop=%b want 1/0/0", valid, cmd, drop);
      end
      pe = 1;
      cycle();
      pe = 0;
      checks++;
      if (drop !== 1'b1) begin
         errors++; $display("FAIL full_drop_pulse: drop=%b want 1", drop);
      end
      cycle();
      checks++;
      if (drop !== 1'b0) begin
         errors++; $display("FAIL full_drop_clear: drop=%b want 0", drop);
      end
      ready = 1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (valid !== 1'b1 || cmd !== 3'(exp[i])) begin
            errors++; $display("FAIL full_drain_%0d: valid=%b cmd=%0d want 1/%0d", i, valid, cmd, exp[i]);
         end
         cycle();
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL full_drain_end: valid=%b want 0", valid);
      end
   endtask

   task automatic test_full_pop();
      int exp [4] = '{4, 3, 2, 1};
      fill_fifo();
      // pop and a new RIGHT event while RIGHT is still pending and FIFO full
      ready = 1; pe = 1;
      cycle();
      ready = 0; pe = 0;
      checks++;
      if (drop !== 1'b1 || valid !== 1'b1 || cmd !== 3'd4) begin
         errors++; $display("FAIL fullpop_nopush: drop=%b valid=%b cmd=%0d want 1/1/4", drop, valid, cmd);
      end
      cycle();
      checks++;
      if (drop !== 1'b0) begin
         errors++; $display("FAIL fullpop_drop_clear: drop=%b want 0", drop);
      end
      ready = 1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (valid !== 1'b1 || cmd !== 3'(exp[i])) begin
            errors++; $display("FAIL fullpop_drain_%0d: valid=%b cmd=%0d want 1/%0d", i, valid, cmd, exp[i]);
         end
         cycle();
      end
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL fullpop_end: valid=%b want 0", valid);
      end
   endtask

   task automatic test_flush();
      bit want;
      ready = 0;
      pc = 1; pn = 1; pw = 1; ls = 1;
      cycle();
      clr_pulses();
      repeat (3) cycle();
      flush = 1;
      cycle();
      flush = 0;
      checks++;
      if (valid !== 1'b0 || drop !== 1'b0) begin
         errors++; $display("FAIL flush_clear: valid=%b drop=%b want 0/0", valid, drop);
      end
      ready = 1;
      for (int j = 1; j <= 12; j++) begin
         cycle();
         want = (j == 10);
         checks++;
         if (valid !== want || (want && cmd !== 3'd3)) begin
            errors++; $display("FAIL flush_das_j%0d: valid=%b cmd=%0d want valid=%b cmd=3", j, valid, cmd, want);
         end
      end
      ls = 0;
      repeat (4) cycle();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL flush_release: valid=%b want 0", valid);
      end
   endtask

   task automatic test_reset_mid();
      ready = 0;
      pc = 1; pn = 1;
      cycle();
      clr_pulses();
      repeat (2) cycle();
      rst_n = 0;
      #1;
      checks++;
      if (valid !== 1'b0 || cmd !== 3'd0 || drop !== 1'b0) begin
         errors++; $display("FAIL midreset_async: valid=%b cmd=%0d drop=%b want 0/0/0", valid, cmd, drop);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1;
      ready = 1;
      repeat (3) cycle();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL midreset_lost: valid=%b want 0", valid);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         pc = ($urandom_range(5) == 0); pe = ($urandom_range(5) == 0);
         pw = ($urandom_range(5) == 0); ps = ($urandom_range(5) == 0);
         pn = ($urandom_range(5) == 0);
         if ($urandom_range(15) == 0) le = ~le;
         if ($urandom_range(15) == 0) lw = ~lw;
         if ($urandom_range(15) == 0) ls = ~ls;
         ready = ($urandom_range(3) != 0);
         flush = ($urandom_range(199) == 0);
         cycle();
         checks++;
         if (valid !== bit'(q.size() != 0) || cmd !== 3'(vis_cmd()) || drop !== drop_m) begin
            errors++;
            $display("FAIL random_cyc%0d: valid=%b cmd=%0d drop=%b want %b/%0d/%b",
                     n, valid, cmd, drop, q.size() != 0, vis_cmd(), drop_m);
         end
      end
      clr_pulses();
      flush = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_burst();
      test_repeat();
      test_full_drop();
      test_full_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/button_cmd_queue.md
# button_cmd_queue

Converts per-button single-cycle press pulses and held button levels into a queued stream of game commands for the tetris game controller. Adds DAS/ARR-style auto-repeat on the E, W and S buttons. Coalesces bursts into per-command pending flags and hands commands downstream over a valid/ready handshake through a small FIFO. Sits directly downstream of the button pulse detector and upstream of the game state machine.

## Interface
- DAS_DELAY, 24'd6_000_000: cycles a repeatable button must be held before the first repeat (≥2)
- ARR_PERIOD, 24'd1_500_000: cycles between subsequent repeats (≥2)
- FIFO_DEPTH, 4: command FIFO entries (power of two, ≥2)

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- I_PLS_BUTTON_C/E/W/S/N  in  1 each  single-cycle press pulses
- I_LVL_BUTTON_E/W/S  in  1 each  held levels, already synchronized to clk
- I_FLUSH  in  1  synchronous flush of FIFO, pending flags and repeat FSMs
- O_CMD_VALID  out  1  FIFO head valid
- O_CMD  out  3  command code at FIFO head
- I_CMD_READY  in  1  consumer accepts head when O_CMD_VALID & I_CMD_READY
- O_DROP  out  1  one-cycle pulse: an event merged into an already-set pending flag

## Operation
- Commands: ROTATE=0 (C), RIGHT=1 (E), LEFT=2 (W), SOFT_DROP=3 (S), HARD_DROP=4 (N). Codes 5–7 are never emitted.
- Event per command = press pulse OR repeat tick (E/W/S only). An event sets that command's pending flag.
- Event while the flag is already set and not being cleared that edge: flag stays set, O_DROP=1 next cycle.
- Pulse and tick on the same command in the same cycle count as one event, with no drop.
- Arbiter:
  - Combinational from the pending flags.
  - Fixed priority ROTATE > HARD_DROP > SOFT_DROP > LEFT > RIGHT.
  - Pushes one command per cycle when FIFO not full; clears the pushed flag at that edge.
  - An event on the flag being cleared that edge re-sets the flag. No drop.
- FIFO full: no push, even if a pop occurs the same cycle. Pending flags hold.
- Pop on O_CMD_VALID & I_CMD_READY. Empty: O_CMD_VALID=0, O_CMD holds its last value.
- Repeat FSM, one per E/W/S:
  - IDLE: level=1 → DELAY, counter=0.
  - DELAY: counter increments each cycle. At counter==DAS_DELAY-1 with level=1: emit tick, → REPEAT, counter=0.
  - REPEAT: at counter==ARR_PERIOD-1: tick, counter=0.
  - Level=0 in any state → IDLE next edge, no tick that cycle.
  - Counters are 24 bits and never wrap past terminal counts.
- I_FLUSH has priority over all other updates: clears FIFO, pending flags and O_DROP, and forces FSMs to IDLE. Events presented in the flush cycle are discarded.

## Timing
- Reset values: O_CMD_VALID=0, O_CMD=0, O_DROP=0, pending=0, FIFO empty, all FSMs IDLE, counters 0.
- Reset asserted mid-operation: all state returns to reset values immediately. Queued commands are lost.
- Latency: event present in cycle k → pending set at edge k → pushed at edge k+1 → O_CMD_VALID=1 in cycle k+2, when there is no higher-priority contention and FIFO not full.
- First tick is exactly DAS_DELAY cycles after the level is first sampled high. Later ticks are every ARR_PERIOD cycles.
- O_CMD/O_CMD_VALID are driven from registered FIFO state only; no combinational path from I_CMD_READY.
- Throughput: one push and one pop per cycle.

## Structure
- Package `button_cmd_pkg` holds:
  - the cmd_t 3-bit enum and command codes
  - the priority order
  - the repeat FSM state encoding (IDLE/DELAY/REPEAT)
  - the counter width constant 24
- Sub-module `auto_repeat_unit` (level in, tick out, DAS_DELAY/ARR_PERIOD parameters), instanced for E, W and S.
- FIFO is inline: registered array, rd/wr pointers, count.

## Test plan
- Reset, then a single C pulse with READY=1 → O_CMD_VALID in cycle k+2 with O_CMD=0, one beat only.
- C, N, W pulses in the same cycle, READY=1 → O_CMD sequence 0, 4, 2 on consecutive cycles, O_DROP stays 0.
- DAS_DELAY=8, ARR_PERIOD=4: hold W level 20 cycles with a pulse at the start → LEFT commands from the pulse, then ticks at cycles 8, 12, 16. Release → no further ticks.
- READY=0: 4 pulses on distinct buttons fill the FIFO, a 5th is held pending, and a repeat on it → O_DROP=1 for one cycle. Raise READY → 5 commands delivered.
- Full FIFO with simultaneous pop and pending event → no push that cycle, push on the next.
- I_FLUSH with 3 queued commands and S held → O_CMD_VALID=0 next cycle. S repeat restarts the full DAS_DELAY from IDLE.
